mult_div_unit: RTL and testbench

- Multi-cycle HI/LO unit that executes the multiply/divide class of instructions, which the single-cycle ALU deliberately does not compute.
- Sits beside the ALU in stage_ex: stage_ex issues an operation with a start pulse, holds the pipeline while busy is high, then reads hi/lo.
- Iterative radix-2 datapath: one bit per cycle, with a sign-correction cycle at the end.

---
 rtl/mult_div_unit_pkg.sv | 18 +
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared opcode definitions for the HI/LO multiply/divide unit.
// Imported by the unit and by anything that issues requests to it.
package mult_div_unit_pkg;

    localparam int MD_OPT_WIDTH = 3;

    localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_MULT  = 3'd0;
    localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_MULTU = 3'd1;
    localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_DIV   = 3'd2;
    localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_DIVU  = 3'd3;
    localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_MTHI  = 3'd4;
    localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_MTLO  = 3'd5;

    function automatic logic md_opt_legal(input logic [MD_OPT_WIDTH-1:0] o);
        return o <= MD_OPT_MTLO;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// One bit per cycle, then a single sign-correction cycle.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MD_OPT_WIDTH-1:0] opt,
    input  logic [31:0]             opr1,
    input  logic [31:0]             opr2,
    input  logic                    flush,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             hi,
    output logic [31:0]             lo,
    output logic                    illegal_opt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(ITER + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0]   acc, acc_n;
    logic [31:0]   divr, divr_n;
    logic          is_div, is_div_n;
    logic          neg_q, neg_q_n;
    logic          neg_r, neg_r_n;
    logic          div0, div0_n;
    logic [31:0]   hi_n, lo_n;
    logic          done_n;

    logic          legal;
    logic          accept;
    logic          sgn;
    logic [31:0]   a_mag, b_mag;
    logic [32:0]   add_sum;
    logic [33:0]   sub_res;
    logic [63:0]   prod_fix;
    logic [31:0]   q_fix, r_fix;

    assign legal       = md_opt_legal(opt);
    assign illegal_opt = start & ~legal;
    assign busy        = (state != S_IDLE);
    assign accept      = start & ~busy & ~flush & legal;

    // MULT and DIV are the even codes of the four arithmetic ops
    assign sgn   = ~opt[0];
    assign a_mag = (sgn & opr1[31]) ? -opr1 : opr1;
    assign b_mag = (sgn & opr2[31]) ? -opr2 : opr2;

    assign add_sum = {1'b0, acc[63:32]} + {1'b0, divr};
    assign sub_res = {1'b0, acc[63:31]} - {2'b0, divr};

    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = div0 ? '1 : (neg_q ? -acc[31:0] : acc[31:0]);
    assign r_fix    = neg_r ? -acc[63:32] : acc[63:32];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        divr_n   = divr;
        is_div_n = is_div;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        div0_n   = div0;
        hi_n     = hi;
        lo_n     = lo;
        done_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        opt == MD_OPT_MTHI: hi_n = opr1;
                        opt == MD_OPT_MTLO: lo_n = opr1;
                        default: begin
                            acc_n    = {32'b0, a_mag};
                            divr_n   = b_mag;
                            is_div_n = opt[1];
                            neg_q_n  = sgn & (opr1[31] ^ opr2[31]) & (opr2 != 32'b0);
                            neg_r_n  = sgn & opr1[31];
                            div0_n   = opt[1] & (opr2 == 32'b0);
                            cnt_n    = '0;
                            state_n  = S_RUN;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else begin
                    if (is_div) begin
                        if (!sub_res[33])
                            acc_n = {sub_res[31:0], acc[30:0], 1'b1};
                        else
                            acc_n = {acc[62:0], 1'b0};
                    end else begin
                        if (acc[0])
                            acc_n = {add_sum, acc[31:1]};
                        else
                            acc_n = {1'b0, acc[63:1]};
                    end
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state_n = S_FIX;
                end
            end
            S_FIX: begin
                state_n = S_IDLE;
                if (!flush) begin
                    if (is_div)
                        {hi_n, lo_n} = {r_fix, q_fix};
                    else
                        {hi_n, lo_n} = prod_fix;
                    done_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            divr   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            acc    <= acc_n;
            divr   <= divr_n;
            is_div <= is_div_n;
            neg_q  <= neg_q_n;
            neg_r  <= neg_r_n;
            div0   <= div0_n;
            hi     <= hi_n;
            lo     <= lo_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, corner
// sequences and random ops against an arithmetic reference.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  opt;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        illegal_opt;

    int n_chk = 0;
    int n_fail = 0;

    mult_div_unit #(.ITER(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .opt(opt),
        .opr1(opr1),
        .opr2(opr2),
        .flush(flush),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .illegal_opt(illegal_opt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = '0;
        case (o)
            MD_OPT_MULT:  p = 64'(sa * sb);
            MD_OPT_MULTU: p = {32'b0, a} * {32'b0, b};
            MD_OPT_DIV: begin
                if (b == 32'b0) begin
                    p = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'b0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
        endcase
        {rh, rl} = p;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int bcyc, output bit held);
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = hi;
        l0 = lo;
        opt = o;
        opr1 = a;
        opr2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcyc = 0;
        held = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcyc++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int lat, bcyc, k;
        bit held, seen_done;
        logic [31:0] rh, rl, ph, pl;

        vecs[0] = '{"multu_max", MD_OPT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult_neg1", MD_OPT_MULT, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2] = '{"mult_min", MD_OPT_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{"div_7_m2", MD_OPT_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[4] = '{"div_m7_2", MD_OPT_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{"divu_100_7", MD_OPT_DIVU, 32'd100, 32'd7, 32'd2, 32'd14};
        vecs[6] = '{"divu_by0", MD_OPT_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF};
        vecs[7] = '{"div_ovf", MD_OPT_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        vecs[8] = '{"div_neg_by0", MD_OPT_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};

        start = 1'b0;
        flush = 1'b0;
        opt = '0;
        opr1 = '0;
        opr2 = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, lat, bcyc, held);
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].ehi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].elo));
            check({vecs[i].name, "_held"}, 64'(held), 64'h1);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd33);
            if (i == 0) begin
                check("multu_busy_cycles", 64'(bcyc), 64'd33);
                @(negedge clk);
                check("done_one_cycle", 64'(done), 64'h0);
            end
        end

        @(negedge clk);
        opt = MD_OPT_MTHI;
        opr1 = 32'hDEADBEEF;
        start = 1'b1;
        #1;
        check("mthi_not_illegal", 64'(illegal_opt), 64'h0);
        @(negedge clk);
        check("mthi_hi", 64'(hi), 64'hDEADBEEF);
        check("mthi_busy", 64'({busy, done}), 64'h0);
        opt = MD_OPT_MTLO;
        opr1 = 32'h1;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h1);
        check("mtlo_hi_kept", 64'(hi), 64'hDEADBEEF);
        check("mtlo_busy", 64'({busy, done}), 64'h0);

        opt = 3'd7;
        opr1 = 32'h99;
        start = 1'b1;
        #1;
        check("illegal_7", 64'(illegal_opt), 64'h1);
        @(negedge clk);
        opt = 3'd6;
        #1;
        check("illegal_6", 64'(illegal_opt), 64'h1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("illegal_idle", 64'(illegal_opt), 64'h0);
        check("illegal_no_change", 64'({busy, hi, lo}), {31'b0, 1'b0, 32'hDEADBEEF, 32'h1});

        run_op(MD_OPT_DIVU, 32'd100, 32'd7, lat, bcyc, held);
        opt = MD_OPT_MTLO;
        opr1 = 32'hABC;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept_lo", 64'(lo), 64'hABC);
        check("b2b_accept_hi", 64'(hi), 64'd2);

        opt = MD_OPT_DIVU;
        opr1 = 32'd100;
        opr2 = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        opt = MD_OPT_MTHI;
        opr1 = 32'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("busy_start_done", 64'(done), 64'h1);
        check("busy_start_hi", 64'(hi), 64'd2);
        check("busy_start_lo", 64'(lo), 64'd14);

        @(negedge clk);
        ph = hi;
        pl = lo;
        opt = MD_OPT_MULTU;
        opr1 = 32'hFFFFFFFF;
        opr2 = 32'hFFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'h0);
        check("flush_done", 64'(done), 64'h0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("flush_no_done", 64'(seen_done), 64'h0);
        check("flush_hilo_kept", {hi, lo}, {ph, pl});

        opt = MD_OPT_MTHI;
        opr1 = 32'h77;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_beats_start", 64'({busy, hi}), {31'b0, 1'b0, ph});

        opt = MD_OPT_MULT;
        opr1 = 32'd3;
        opr2 = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {hi, lo}, 64'h0);
        check("midrun_reset_flags", 64'({busy, done}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("reset_no_done", 64'(seen_done), 64'h0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) b = -b;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            model(o, a, b, rh, rl);
            run_op(o, a, b, lat, bcyc, held);
            if (hi !== rh || lo !== rl)
                $display("  op=%0d a=0x%h b=0x%h", o, a, b);
            check("rand_hi", 64'(hi), 64'(rh));
            check("rand_lo", 64'(lo), 64'(rl));
            check("rand_latency", 64'(lat), 64'd33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
